// File: rtl/lsu_master_pkg.sv
// Shared opcode constants and decode helpers for the load/store master.
// Opcodes live in Ins[31:26]; JALR is identified by funct Ins[5:0] under R_FORM.
package lsu_master_pkg;

  localparam logic [5:0] OP_R_FORM = 6'h00;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] FN_JALR   = 6'h09;

  function automatic logic is_mem_op(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Halfword ops need an even address, word ops a word-aligned one.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return |off;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane logic: store byte enables / data replication and
// load lane selection with sign or zero extension.
module lsu_align
  import lsu_master_pkg::*;
(
  input  logic [5:0]  i_stOp,
  input  logic [1:0]  i_stOff,
  input  logic [31:0] i_stData,
  input  logic [5:0]  i_ldOp,
  input  logic [1:0]  i_ldOff,
  input  logic [31:0] i_ldRaw,
  output logic [3:0]  o_be,
  output logic [31:0] o_stLanes,
  output logic [31:0] o_ldData
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Narrow stores replicate the datum across all lanes; enables pick the lane.
  always_comb begin
    o_be      = 4'b1111;
    o_stLanes = i_stData;
    case (i_stOp)
      OP_SB: begin
        o_be      = 4'b0001 << i_stOff;
        o_stLanes = {4{i_stData[7:0]}};
      end
      OP_SH: begin
        o_be      = i_stOff[1] ? 4'b1100 : 4'b0011;
        o_stLanes = {2{i_stData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (i_ldOff)
      2'd0:    w_byte = i_ldRaw[7:0];
      2'd1:    w_byte = i_ldRaw[15:8];
      2'd2:    w_byte = i_ldRaw[23:16];
      default: w_byte = i_ldRaw[31:24];
    endcase
    w_half = i_ldOff[1] ? i_ldRaw[31:16] : i_ldRaw[15:0];
    case (i_ldOp)
      OP_LB:   o_ldData = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_ldData = {24'h0, w_byte};
      OP_LH:   o_ldData = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_ldData = {16'h0, w_half};
      default: o_ldData = i_ldRaw;
    endcase
  end

endmodule

// File: rtl/lsu_master.sv
// Multi-cycle load/store initiator: stalls the core while one handshaked
// memory request per instruction is outstanding, with a watchdog abort.
module lsu_master
  import lsu_master_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       Ins,
  input  logic [31:0]       Result,
  input  logic [31:0]       Rdata2,
  input  logic [31:0]       nextPC,
  output logic [31:0]       Wdata,
  output logic              Stall,
  output logic              AdrErr,
  output logic              BusErr,
  output logic              mreq,
  output logic              mwe,
  output logic [ADDR_W-1:0] maddr,
  output logic [3:0]        mbe,
  output logic [31:0]       mwdata,
  input  logic [31:0]       mrdata,
  input  logic              mack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t            r_state;
  state_t            w_nextState;
  logic              r_mreq;
  logic              r_mwe;
  logic [ADDR_W-1:0] r_maddr;
  logic [3:0]        r_mbe;
  logic [31:0]       r_mwdata;
  logic [5:0]        r_op;
  logic [1:0]        r_off;
  logic [31:0]       r_rdata;
  logic [WD_W-1:0]   r_wd;
  logic              r_abort;

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic        w_memOp;
  logic        w_misaligned;
  logic        w_start;
  logic        w_expire;
  logic        w_isLink;
  logic [3:0]  w_be;
  logic [31:0] w_stLanes;
  logic [31:0] w_ldData;
  logic        w_unusedIns;

  assign w_op         = Ins[31:26];
  assign w_funct      = Ins[5:0];
  assign w_unusedIns  = ^Ins[25:6];
  assign w_memOp      = is_mem_op(w_op);
  assign w_misaligned = is_misaligned(w_op, Result[1:0]);
  assign w_start      = (r_state == S_IDLE) && w_memOp && !w_misaligned;
  assign w_expire     = (r_state == S_REQ) && !mack && (r_wd == WD_W'(TIMEOUT - 1));
  assign w_isLink     = (w_op == OP_JAL) || ((w_op == OP_R_FORM) && (w_funct == FN_JALR));

  lsu_align u_align (
    .i_stOp    (w_op),
    .i_stOff   (Result[1:0]),
    .i_stData  (Rdata2),
    .i_ldOp    (r_op),
    .i_ldOff   (r_off),
    .i_ldRaw   (r_rdata),
    .o_be      (w_be),
    .o_stLanes (w_stLanes),
    .o_ldData  (w_ldData)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  // An ack arriving on the expiry cycle wins over the abort.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_nextState = S_REQ;
      S_REQ:   if (mack || w_expire) w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mreq   <= 1'b0;
      r_mwe    <= 1'b0;
      r_maddr  <= '0;
      r_mbe    <= 4'h0;
      r_mwdata <= 32'h0;
      r_op     <= 6'h0;
      r_off    <= 2'h0;
      r_rdata  <= 32'h0;
      r_wd     <= '0;
      r_abort  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_mreq   <= 1'b1;
          r_mwe    <= is_store(w_op);
          r_maddr  <= Result[ADDR_W+1:2];
          r_mbe    <= w_be;
          r_mwdata <= w_stLanes;
          r_op     <= w_op;
          r_off    <= Result[1:0];
          r_rdata  <= 32'h0;
          r_wd     <= '0;
          r_abort  <= 1'b0;
        end
        S_REQ: begin
          if (mack) begin
            r_mreq  <= 1'b0;
            r_rdata <= mrdata;
          end else if (w_expire) begin
            r_mreq  <= 1'b0;
            r_abort <= 1'b1;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The core only commits when Stall is low, so Wdata matters in DONE and on non-stalling IDLE cycles.
  always_comb begin
    Stall  = 1'b0;
    AdrErr = 1'b0;
    BusErr = 1'b0;
    Wdata  = Result;
    case (r_state)
      S_IDLE: begin
        if (w_memOp) begin
          if (w_misaligned) begin
            AdrErr = 1'b1;
            Wdata  = 32'h0;
          end else begin
            Stall = 1'b1;
          end
        end else if (w_isLink) begin
          Wdata = nextPC;
        end
      end
      S_REQ: Stall = 1'b1;
      S_DONE: begin
        BusErr = r_abort;
        if (!is_store(r_op)) Wdata = r_abort ? 32'h0 : w_ldData;
      end
      default: ;
    endcase
    if (RST) begin
      Stall  = 1'b0;
      AdrErr = 1'b0;
      BusErr = 1'b0;
    end
  end

  assign mreq   = r_mreq & ~RST;
  assign mwe    = r_mwe & ~RST;
  assign maddr  = RST ? '0 : r_maddr;
  assign mbe    = RST ? 4'h0 : r_mbe;
  assign mwdata = RST ? 32'h0 : r_mwdata;

endmodule

// File: doc/lsu_master.md
# lsu_master

Multi-cycle load/store initiator placed between the single-cycle MIPS datapath and a handshaked data-memory port. It decodes memory opcodes from `Ins` and issues one request per instruction. It stalls the core until the memory acknowledges, then returns lane-aligned, sign/zero-extended load data on the writeback path. It also adds byte and halfword access, alignment checking and a bus watchdog.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address width; `maddr` = `Result[ADDR_W+1:2]`.
- `TIMEOUT`, default 16: maximum REQ cycles without `mack` before abort.

Ports:
- `CLK`, in, 1: clock.
- `RST`, in, 1: reset, synchronous, active-high.
- `Ins`, in, 32: current instruction. The core holds it stable while `Stall`=1.
- `Result`, in, 32: ALU effective byte address / ALU result.
- `Rdata2`, in, 32: store data.
- `nextPC`, in, 32: PC+4, the link value.
- `Wdata`, out, 32: register writeback data.
- `Stall`, out, 1: core must not advance PC or commit state.
- `AdrErr`, out, 1: one-cycle pulse on a misaligned access.
- `BusErr`, out, 1: one-cycle pulse on a watchdog abort.
- `mreq`, out, 1: memory request, registered.
- `mwe`, out, 1: write enable.
- `maddr`, out, `ADDR_W`: word address.
- `mbe`, out, 4: byte enables. Bit *n* is byte lane `[8n+7:8n]` (little-endian lanes).
- `mwdata`, out, 32: write data.
- `mrdata`, in, 32: read data, valid when `mack`=1.
- `mack`, in, 1: acknowledge, sampled only while `mreq`=1.

## Operation
- Memory opcodes are LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B. Every other opcode is a non-memory op.
- Non-memory op: no request, `Stall`=0. `Wdata` = `nextPC` if opcode is JAL, or if opcode is R_FORM with funct JALR. Otherwise `Wdata` = `Result`.
- Alignment rules:
  - LH/LHU/SH require `Result[0]`=0.
  - LW/SW require `Result[1:0]`=0.
  - On a violation: no request, `AdrErr`=1 for that cycle, `Stall`=0, `Wdata`=0.
- The FSM has three states: IDLE, REQ and DONE.
- IDLE, aligned memory op:
  - `Stall`=1, combinationally.
  - Capture opcode, `Result[1:0]`, address, write data and byte enables.
  - Next state REQ, with `mreq`=1.
- REQ:
  - `Stall`=1. `mreq`, `mwe`, `maddr`, `mbe` and `mwdata` are held constant.
  - On `mack`: capture `mrdata`, clear `mreq`, go to DONE.
  - Watchdog counter increments each REQ cycle without `mack`. When it reaches `TIMEOUT`: clear `mreq`, set the abort flag, go to DONE.
- DONE:
  - `Stall`=0 and the core commits at the end of this cycle.
  - Loads: `Wdata` = extracted captured data. Aborted loads give 0.
  - Stores: `Wdata` = `Result`.
  - `BusErr`=1 if the access was aborted.
  - Next state is always IDLE. The same instruction is never reissued.
- Store lanes:
  - SB: `mbe`=1<<`Result[1:0]`, `mwdata`=`{4{Rdata2[7:0]}}`.
  - SH: `mbe`=`Result[1]`?1100:0011, `mwdata`=`{2{Rdata2[15:0]}}`.
  - SW: `mbe`=1111, `mwdata`=`Rdata2`.
  - Loads: `mbe`=1111, `mwe`=0.
- Load extraction:
  - LB/LBU select the byte at offset `Result[1:0]`.
  - LH/LHU select the halfword at `Result[1]`.
  - LB/LH sign-extend. LBU/LHU zero-extend.
- `mack` outside REQ is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `mreq`=0, `mwe`=0, `maddr`=0, `mbe`=0, `mwdata`=0.
  - Captured data 0, watchdog 0.
  - `AdrErr`=0, `BusErr`=0.
  - While `RST`=1, `Stall` and all request outputs are forced to 0.
- `RST` asserted during REQ: `mreq` is 0 from the next cycle and the access is abandoned with no `BusErr`.
- Minimum memory access (`mack` in the first REQ cycle) costs 3 cycles: IDLE(stall), REQ(stall), DONE.
- With ack latency *k* ≥ 1 REQ cycles, `Stall` is high for 1+*k* cycles.
- Abort: `Stall` is high for 1+`TIMEOUT` cycles, then DONE with `BusErr`.
- `mack` arriving together with watchdog expiry counts as a successful ack.
- Back-to-back memory instructions: DONE→IDLE, then the new instruction is detected in IDLE. There is no bubble beyond the IDLE stall cycle.

## Structure
- Add the new opcode constants (LB, LH, LBU, LHU, SB, SH) to `common_param.vh`, beside LW, SW, JAL, JALR and R_FORM.
- The state encoding is a localparam in the block.
- Sub-module `lsu_align` is purely combinational and computes:
  - store byte enables and lane replication;
  - load lane select and sign/zero extension.
- `lsu_master` itself holds only the FSM, capture registers and watchdog.

## Test plan
- SW, `Result`=0x10, `Rdata2`=0xDEADBEEF, `mack` on the 2nd REQ cycle → `maddr`=4, `mbe`=1111, `mwe`=1, `mwdata`=0xDEADBEEF; `Stall` high exactly 3 cycles.
- LB, `Result`=0x13, `mrdata`=0x80FF1234 → `Wdata`=0xFFFFFF80 in DONE. LBU, same stimulus → 0x00000080.
- LH, `Result`=0x2, `mrdata`=0x80FF1234 → `Wdata`=0xFFFF80FF. LHU, same stimulus → 0x000080FF.
- SB, `Result`=0x5, `Rdata2`=0x000000AB → `maddr`=1, `mbe`=0010, `mwdata`=0xABABABAB.
- LW, `Result`=0x6 → `AdrErr` one-cycle pulse, `mreq` never asserted, `Stall`=0, `Wdata`=0.
- Watchdog and reset:
  - LW with `mack` tied low, `TIMEOUT`=16 → `mreq` high 16 cycles, then DONE with `BusErr`=1 and `Wdata`=0.
  - Repeat the LW with `RST` in REQ cycle 3 → `mreq`=0 next cycle, no `BusErr`.
  - JAL → `Wdata`=`nextPC`, `Stall`=0.
